digit_serial_adder: RTL and testbench

//   Multi-cycle, parametrised adder that sums two WIDTH-bit operands plus carry-in, DIGIT bits per clock.

---
 rtl/digit_serial_adder_if.sv | 25 ++
 rtl/digit_serial_adder.sv | 117 +++++++++++
 tb/tb_digit_serial_adder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle between an issuing controller and the digit-serial adder.
// The master drives start and operands; the slave returns status and the result.
interface digit_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in DIGIT bits per clock,
// with start/busy/done handshake and a signed-overflow flag.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    digit_serial_adder_if.slave bus
);
    localparam int unsigned NDIG  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((DIGIT < 1) || ((WIDTH % ((DIGIT > 0) ? DIGIT : 1)) != 0)) begin : g_bad_params
            $fatal(1, "digit_serial_adder: WIDTH must be a nonzero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_dsum;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_acc_next;

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit MSB recovered from its sum bit; only meaningful on the final digit.
    assign w_msb_cin  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];
    assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (r_cnt == CNT_W'(NDIG - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == StRun) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Visible result only moves on the final digit, keeping s/cout/ovf stable during RUN.
            if (w_last) begin
                r_s    <= w_acc_next;
                r_cout <= w_dsum[DIGIT];
                r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
            end
        end
    end

    assign bus.busy = (r_state == StRun);
    assign bus.done = (r_state == StDone);
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: two adder instances (16/4 and 4/1) checked against an integer model.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(16)) bus0 ();
    digit_serial_adder_if #(.WIDTH(4))  bus1 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
    digit_serial_adder #(.WIDTH(4),  .DIGIT(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [17:0] prev [2];
    int          bcnt [2];

    function automatic void check(string name, longint got, longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Integer reference: unsigned sum gives s/cout, signed sum out of range gives ovf.
    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, int c);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        int sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        int sum = ua + ub + int'(cin);
        int ss  = sa + sb + int'(cin);
        e.s    = 16'(sum % (1 << w));
        e.cout = ((sum >> w) & 1) != 0;
        e.ovf  = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
        e.cyc  = c;
        return e;
    endfunction

    task automatic mon(int u, logic busy, logic done, logic [15:0] s, logic cout, logic ovf);
        exp_t e;
        if (rst) begin
            check($sformatf("rst_busy%0d", u), busy, 0);
            check($sformatf("rst_done%0d", u), done, 0);
            check($sformatf("rst_s%0d", u), s, 0);
            check($sformatf("rst_cout%0d", u), cout, 0);
            check($sformatf("rst_ovf%0d", u), ovf, 0);
            bcnt[u] = 0;
        end else if (done) begin
            if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                check($sformatf("unexpected_done%0d", u), 1, 0);
            end else begin
                e = (u == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("s%0d", u), s, e.s);
                check($sformatf("cout%0d", u), cout, e.cout);
                check($sformatf("ovf%0d", u), ovf, e.ovf);
                check($sformatf("latency%0d", u), cyc, e.cyc);
                check($sformatf("busy_len%0d", u), bcnt[u], 4);
            end
            bcnt[u] = 0;
        end else begin
            check($sformatf("result_stable%0d", u), {s, cout, ovf}, prev[u]);
            if (busy) bcnt[u]++;
        end
        prev[u] = {s, cout, ovf};
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mon(0, bus0.busy, bus0.done, bus0.s, bus0.cout, bus0.ovf);
            mon(1, bus1.busy, bus1.done, 16'(bus1.s), bus1.cout, bus1.ovf);
        end
    end

    task automatic wait_idle(int u);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((u == 0 ? bus0.busy : bus1.busy) && n < 50);
        if (n >= 50) check($sformatf("idle_timeout%0d", u), n, 0);
    endtask

    task automatic issue(int u, logic [15:0] a, logic [15:0] b, logic cin);
        wait_idle(u);
        if (u == 0) begin
            bus0.start = 1'b1; bus0.a = a; bus0.b = b; bus0.cin = cin;
            q0.push_back(model(16, a, b, cin, cyc + 5));
        end else begin
            bus1.start = 1'b1; bus1.a = a[3:0]; bus1.b = b[3:0]; bus1.cin = cin;
            q1.push_back(model(4, 16'(a[3:0]), 16'(b[3:0]), cin, cyc + 5));
        end
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    initial begin
        int n;
        bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        prev[0] = '0; prev[1] = '0; bcnt[0] = 0; bcnt[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(0, 16'h0003, 16'h000C, 1'b0);
        issue(0, 16'hFFFF, 16'h0000, 1'b1);
        issue(0, 16'h7FFF, 16'h0001, 1'b0);
        issue(0, 16'h8000, 16'h8000, 1'b0);

        // start held high from IDLE through the following DONE: two back-to-back results
        wait_idle(0);
        bus0.start = 1'b1; bus0.a = 16'h1234; bus0.b = 16'h8765; bus0.cin = 1'b1;
        q0.push_back(model(16, 16'h1234, 16'h8765, 1'b1, cyc + 5));
        q0.push_back(model(16, 16'h1234, 16'h8765, 1'b1, cyc + 10));
        repeat (6) @(negedge clk);
        bus0.start = 1'b0;

        // start pulse and operand changes mid-RUN must be ignored
        issue(0, 16'hA5A5, 16'h5A5A, 1'b1);
        @(negedge clk);
        bus0.start = 1'b1; bus0.a = 16'(($urandom)); bus0.b = 16'(($urandom)); bus0.cin = 1'b0;
        @(negedge clk);
        bus0.start = 1'b0;

        // reset in RUN cycle 2 abandons the operation
        issue(0, 16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(0, 16'h00FF, 16'h0F01, 1'b0);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(0, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        issue(1, 16'h7, 16'h0, 1'b1);
        issue(1, 16'h3, 16'hC, 1'b1);
        issue(1, 16'hF, 16'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", q0.size() + q1.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
